// File: rtl/video_timing_if.sv
// Raster timing bundle from the timing generator to a pixel source.
// master: driven by video_timing_gen.  slave: consumed by the pixel source.
//   o_HSync/o_VSync   sync levels (polarity set by the generator)
//   o_DE              visible-pixel enable
//   o_X/o_Y           visible coordinates, 0 outside active
//   o_LineStart       one-cycle strobe at h=0
//   o_FrameStart      one-cycle strobe at h=0, v=0
//   o_Fetch/X/Y       one-step look-ahead of o_DE/o_X/o_Y (0 when not built)
interface video_timing_if #(
    parameter int unsigned CW = 12
);
    logic          o_HSync;
    logic          o_VSync;
    logic          o_DE;
    logic [CW-1:0] o_X;
    logic [CW-1:0] o_Y;
    logic          o_LineStart;
    logic          o_FrameStart;
    logic          o_Fetch;
    logic [CW-1:0] o_FetchX;
    logic [CW-1:0] o_FetchY;

    modport master (
        output o_HSync, o_VSync, o_DE, o_X, o_Y,
               o_LineStart, o_FrameStart, o_Fetch, o_FetchX, o_FetchY
    );

    modport slave (
        input  o_HSync, o_VSync, o_DE, o_X, o_Y,
               o_LineStart, o_FrameStart, o_Fetch, o_FetchX, o_FetchY
    );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator.
// Counts pixels (h) and lines (v) on enabled cycles and registers sync,
// data-enable, coordinates and line/frame strobes decoded from the counter
// value before each increment.
// Ports:
//   i_Clk    pixel-domain clock, all logic on posedge
//   i_Rst_n  synchronous active-low reset, priority over i_CE
//   i_CE     pixel enable; the raster advances only when high
//   vid      video_timing_if.master output bundle
// Optional feature: define VTG_LOOKAHEAD_EN to build the fetch look-ahead
// decoder; otherwise o_Fetch/o_FetchX/o_FetchY are tied to 0.
module video_timing_gen #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned CW       = 12
) (
    input  logic           i_Clk,
    input  logic           i_Rst_n,
    input  logic           i_CE,
    video_timing_if.master vid
);
    localparam int unsigned H_ACT_START = H_SYNC + H_BP;
    localparam int unsigned H_ACT_END   = H_ACT_START + H_ACTIVE;
    localparam int unsigned H_TOTAL     = H_ACT_END + H_FP;
    localparam int unsigned V_ACT_START = V_SYNC + V_BP;
    localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE;
    localparam int unsigned V_TOTAL     = V_ACT_END + V_FP;
    localparam bit CFG_OK = (64'(H_TOTAL) <= (64'd1 << CW)) &&
                            (64'(V_TOTAL) <= (64'd1 << CW));

    logic [CW-1:0] h_q, v_q, h_nxt, v_nxt;
    logic          hs_q, vs_q, de_q, ls_q, fs_q;
    logic [CW-1:0] x_q, y_q;
    logic          cur_hs, cur_vs, cur_de;
    logic [CW-1:0] cur_x, cur_y;

    // Region decode of one counter position; compares run at 32 bits so a
    // region end equal to 2^CW does not wrap.
    function automatic void decode(
        input  logic [CW-1:0] h,
        input  logic [CW-1:0] v,
        output logic          hs,
        output logic          vs,
        output logic          de,
        output logic [CW-1:0] x,
        output logic [CW-1:0] y
    );
        logic h_act;
        logic v_act;
        h_act = (32'(h) >= H_ACT_START) && (32'(h) < H_ACT_END);
        v_act = (32'(v) >= V_ACT_START) && (32'(v) < V_ACT_END);
        hs    = (32'(h) < H_SYNC) ? H_POL : ~H_POL;
        vs    = (32'(v) < V_SYNC) ? V_POL : ~V_POL;
        de    = h_act && v_act;
        x     = de    ? (h - CW'(H_ACT_START)) : '0;
        y     = v_act ? (v - CW'(V_ACT_START)) : '0;
    endfunction

    // Counter successor: wrap h at end of line, v at end of frame.
    always_comb begin
        h_nxt = h_q + CW'(1);
        v_nxt = v_q;
        if (32'(h_q) == H_TOTAL - 1) begin
            h_nxt = '0;
            v_nxt = (32'(v_q) == V_TOTAL - 1) ? '0 : v_q + CW'(1);
        end
    end

    // Decode of the current counter position.
    always_comb begin
        decode(h_q, v_q, cur_hs, cur_vs, cur_de, cur_x, cur_y);
    end

    // Counters and registered outputs; levels hold while i_CE is low.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            h_q  <= '0;
            v_q  <= '0;
            hs_q <= ~H_POL;
            vs_q <= ~V_POL;
            de_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            ls_q <= i_CE && (h_q == '0);
            fs_q <= i_CE && (h_q == '0) && (v_q == '0);
            if (i_CE) begin
                h_q  <= h_nxt;
                v_q  <= v_nxt;
                hs_q <= cur_hs;
                vs_q <= cur_vs;
                de_q <= cur_de;
                x_q  <= cur_x;
                y_q  <= cur_y;
            end
        end
    end

    assign vid.o_HSync      = hs_q;
    assign vid.o_VSync      = vs_q;
    assign vid.o_DE         = de_q;
    assign vid.o_X          = x_q;
    assign vid.o_Y          = y_q;
    assign vid.o_LineStart  = ls_q;
    assign vid.o_FrameStart = fs_q;

`ifdef VTG_LOOKAHEAD_EN
    logic          nxt_hs_unused, nxt_vs_unused, nxt_de;
    logic [CW-1:0] nxt_x, nxt_y;
    logic          f_q;
    logic [CW-1:0] fx_q, fy_q;

    // Decode of the position the counters move to on this enabled step,
    // i.e. what o_DE/o_X/o_Y will show after the following enabled edge.
    always_comb begin
        decode(h_nxt, v_nxt, nxt_hs_unused, nxt_vs_unused, nxt_de, nxt_x, nxt_y);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            f_q  <= 1'b0;
            fx_q <= '0;
            fy_q <= '0;
        end else if (i_CE) begin
            f_q  <= nxt_de;
            fx_q <= nxt_x;
            fy_q <= nxt_y;
        end
    end

    assign vid.o_Fetch  = f_q;
    assign vid.o_FetchX = fx_q;
    assign vid.o_FetchY = fy_q;
`else
    assign vid.o_Fetch  = 1'b0;
    assign vid.o_FetchX = '0;
    assign vid.o_FetchY = '0;
`endif

    // Mode totals must fit the counter width.
    always @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            assert (CFG_OK)
            else $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 2^CW");
        end
    end
endmodule
